// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: decode-side control (stall/redirect), the
// instruction-memory request/acknowledge channel and the registered
// instruction handed to decode. The fetch unit uses the master modport;
// the surrounding pipeline/memory uses the slave modport.
interface if_fetch_if;
    // Control from downstream stages
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Instruction-memory channel
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Instruction delivered to decode
    logic [31:0] ins;
    logic [31:0] npc_o;
    logic        ins_valid;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  mem_ack,
        input  mem_rdata,
        output mem_req,
        output mem_addr,
        output ins,
        output npc_o,
        output ins_valid
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output mem_ack,
        output mem_rdata,
        input  mem_req,
        input  mem_addr,
        input  ins,
        input  npc_o,
        input  ins_valid
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage.
// Issues one word-aligned read per cycle while in REQ, keeps the address
// stable until the memory acknowledges, and hands the returned word to
// decode together with its fall-through address. A decode stall that
// coincides with an acknowledge parks the word in a one-entry hold buffer
// (state HOLD, no request). Redirects win over stall; a redirect that
// arrives while a request is still outstanding is remembered as pending,
// and the late data for the abandoned address is dropped on its ack.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_if.master    bus
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] hold_ins_reg;
    logic [31:0] hold_npc_reg;
    logic        pend_reg;
    logic [31:0] pend_pc_reg;
    logic [31:0] ins_reg;
    logic [31:0] npc_reg;
    logic        ins_valid_reg;
    // Tracks state==S_REQ except in the first cycle after reset release,
    // so the request line stays low while reset is asserted.
    logic        mem_req_reg;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        stall;
    logic        redirect;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    assign stall     = bus.stall;
    assign redirect  = bus.redirect;
    assign mem_ack   = bus.mem_ack;
    assign mem_rdata = bus.mem_rdata;

    // Sequential fall-through address; wraps naturally at 2^32.
    assign pc_plus4 = pc_reg + 32'd4;

    // Branch targets are forced to word alignment.
    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    // Fetch FSM: pc, hold buffer, pending redirect and decode outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_REQ;
            pc_reg        <= RESET_PC;
            hold_ins_reg  <= 32'h0000_0000;
            hold_npc_reg  <= 32'h0000_0000;
            pend_reg      <= 1'b0;
            pend_pc_reg   <= 32'h0000_0000;
            ins_reg       <= 32'h0000_0000;
            npc_reg       <= 32'h0000_0000;
            ins_valid_reg <= 1'b0;
            mem_req_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    mem_req_reg <= 1'b1;
                    if (!mem_req_reg) begin
                        // First cycle out of reset: nothing outstanding yet,
                        // so a redirect can be applied to pc directly.
                        if (redirect) begin
                            pc_reg        <= redirect_target;
                            ins_reg       <= 32'h0000_0000;
                            ins_valid_reg <= 1'b0;
                        end
                    end else if (redirect) begin
                        ins_reg       <= 32'h0000_0000;
                        ins_valid_reg <= 1'b0;
                        if (mem_ack) begin
                            // Request completes now: drop the data, jump.
                            pc_reg   <= redirect_target;
                            pend_reg <= 1'b0;
                        end else begin
                            // Request still in flight: keep mem_addr stable
                            // and remember where to go once it is acked.
                            // A newer redirect simply overwrites the target.
                            pend_reg    <= 1'b1;
                            pend_pc_reg <= redirect_target;
                        end
                    end else if (mem_ack && pend_reg) begin
                        // Late data for an abandoned address: discard it.
                        pc_reg   <= pend_pc_reg;
                        pend_reg <= 1'b0;
                        if (!stall) begin
                            ins_reg       <= 32'h0000_0000;
                            ins_valid_reg <= 1'b0;
                        end
                    end else if (mem_ack) begin
                        pc_reg <= pc_plus4;
                        if (stall) begin
                            // Decode is busy: park the word and stop
                            // requesting until it has been handed over.
                            hold_ins_reg <= mem_rdata;
                            hold_npc_reg <= pc_plus4;
                            state_reg    <= S_HOLD;
                            mem_req_reg  <= 1'b0;
                        end else begin
                            ins_reg       <= mem_rdata;
                            npc_reg       <= pc_plus4;
                            ins_valid_reg <= 1'b1;
                        end
                    end else if (!stall) begin
                        // Memory wait state: present a bubble to decode.
                        ins_reg       <= 32'h0000_0000;
                        ins_valid_reg <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        // Parked word is on the wrong path: drop it and
                        // request the target immediately, even under stall.
                        pc_reg        <= redirect_target;
                        hold_ins_reg  <= 32'h0000_0000;
                        hold_npc_reg  <= 32'h0000_0000;
                        ins_reg       <= 32'h0000_0000;
                        ins_valid_reg <= 1'b0;
                        state_reg     <= S_REQ;
                        mem_req_reg   <= 1'b1;
                    end else if (!stall) begin
                        ins_reg       <= hold_ins_reg;
                        npc_reg       <= hold_npc_reg;
                        ins_valid_reg <= 1'b1;
                        state_reg     <= S_REQ;
                        mem_req_reg   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_addr  = pc_reg;
    assign bus.ins       = ins_reg;
    assign bus.npc_o     = npc_reg;
    assign bus.ins_valid = ins_valid_reg;

endmodule
